// File: rtl/des_decryption_iterative.sv
// Iterative DES engine: one shared round function stepped 16 times between IP and IP^-1.
// With REVERSE_KEYS=1 the schedule runs K16..K1 (decrypt); with 0 it runs K1..K16 (encrypt).

module ip_permutation (
  input  logic [1:64] din,
  output logic [1:64] dout
);
  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17,  9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};

  always_comb begin
    dout = '0;
    for (int i = 0; i < 64; i++) dout[i+1] = din[IP_T[i]];
  end
endmodule

module ip_inverse_permutation (
  input  logic [1:64] din,
  output logic [1:64] dout
);
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41,  9, 49, 17, 57, 25};

  always_comb begin
    dout = '0;
    for (int i = 0; i < 64; i++) dout[i+1] = din[FP_T[i]];
  end
endmodule

module des_roundfunction (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:32] l_in,
  input  logic [1:32] r_in,
  input  logic [1:48] kn,
  output logic [1:32] l_out,
  output logic [1:32] r_out,
  output logic        done
);
  localparam int E_T [48] = '{
    32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,  8,  9, 10, 11,
    12, 13, 12, 13, 14, 15, 16, 17, 16, 17, 18, 19, 20, 21, 20, 21,
    22, 23, 24, 25, 24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1};

  localparam int P_T [32] = '{
    16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
     2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25};

  // One entry per S-box row (box*4 + row); column c is the nibble at bits [63-4c -: 4].
  localparam logic [63:0] SBOX [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  function automatic logic [1:32] f_func(input logic [1:32] r, input logic [1:48] k);
    logic [1:48] x;
    logic [1:32] s;
    logic [5:0]  b;
    logic [63:0] row;
    logic [1:32] f;
    x = '0;
    s = '0;
    f = '0;
    for (int i = 0; i < 48; i++) x[i+1] = r[E_T[i]] ^ k[i+1];
    for (int j = 0; j < 8; j++) begin
      b   = x[6*j+1 +: 6];
      row = SBOX[j*4 + int'({b[5], b[0]})];
      s[4*j+1 +: 4] = row[63 - 4*int'(b[4:1]) -: 4];
    end
    for (int i = 0; i < 32; i++) f[i+1] = s[P_T[i]];
    return f;
  endfunction

  logic [1:32] l_out_q, l_out_d;
  logic [1:32] r_out_q, r_out_d;
  logic        done_q,  done_d;

  always_comb begin
    l_out_d = l_out_q;
    r_out_d = r_out_q;
    done_d  = start;
    if (start) begin
      l_out_d = r_in;
      r_out_d = l_in ^ f_func(r_in, kn);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      l_out_q <= '0;
      r_out_q <= '0;
      done_q  <= 1'b0;
    end else begin
      l_out_q <= l_out_d;
      r_out_q <= r_out_d;
      done_q  <= done_d;
    end
  end

  assign l_out = l_out_q;
  assign r_out = r_out_q;
  assign done  = done_q;
endmodule

module des_decryption_iterative #(
  parameter int REVERSE_KEYS = 1,
  parameter int ROUNDS       = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [1:64]  ciphertext,
  input  logic [1:768] round_keys,
  output logic         busy,
  output logic         done,
  output logic [1:64]  result
);
  typedef enum logic [1:0] {S_IDLE, S_RSTART, S_RWAIT} state_t;

  state_t       state_q,  state_d;
  logic [3:0]   cnt_q,    cnt_d;
  logic [1:32]  l_q,      l_d;
  logic [1:32]  r_q,      r_d;
  logic [1:768] keys_q,   keys_d;
  logic [1:64]  result_q, result_d;
  logic         done_q,   done_d;

  logic [1:64]  ip_out;
  logic [1:64]  fp_out;
  logic [3:0]   key_sel;
  logic [9:0]   key_base;
  logic [1:48]  kn;
  logic         rf_start;
  logic         rf_rst_n;
  logic [1:32]  rf_l;
  logic [1:32]  rf_r;
  logic         rf_done;

  ip_permutation u_ip (
    .din  (ciphertext),
    .dout (ip_out)
  );

  // Final swap is folded in here: the output permutation sees {R16, L16}.
  ip_inverse_permutation u_fp (
    .din  ({rf_r, rf_l}),
    .dout (fp_out)
  );

  always_comb begin
    key_sel  = (REVERSE_KEYS != 0) ? (4'd15 - cnt_q) : cnt_q;
    key_base = 10'(key_sel) * 10'd48 + 10'd1;
    kn       = keys_q[key_base +: 48];
  end

  assign rf_rst_n = ~rst;

  des_roundfunction u_rf (
    .clk   (clk),
    .rst_n (rf_rst_n),
    .start (rf_start),
    .l_in  (l_q),
    .r_in  (r_q),
    .kn    (kn),
    .l_out (rf_l),
    .r_out (rf_r),
    .done  (rf_done)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    l_d      = l_q;
    r_d      = r_q;
    keys_d   = keys_q;
    result_d = result_q;
    done_d   = 1'b0;
    rf_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          l_d     = ip_out[1:32];
          r_d     = ip_out[33:64];
          keys_d  = round_keys;
          cnt_d   = 4'd0;
          state_d = S_RSTART;
        end
      end
      S_RSTART: begin
        rf_start = 1'b1;
        state_d  = S_RWAIT;
      end
      S_RWAIT: begin
        if (rf_done) begin
          l_d = rf_l;
          r_d = rf_r;
          // Terminal compare precedes the increment, so the 4-bit counter never wraps.
          if (cnt_q == 4'(ROUNDS - 1)) begin
            result_d = fp_out;
            done_d   = 1'b1;
            state_d  = S_IDLE;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = S_RSTART;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      l_q      <= '0;
      r_q      <= '0;
      keys_q   <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      l_q      <= l_d;
      r_q      <= r_d;
      keys_q   <= keys_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign ready  = (state_q == S_IDLE);
  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = result_q;
endmodule

// File: tb/tb_des_decryption_iterative.sv
// Directed bench for des_decryption_iterative: a decrypt instance and an encrypt-order
// instance, each with a queue of expected results checked whenever done pulses.

module tb_des_decryption_iterative;
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  localparam logic [1:64] PT_FIPS = 64'h0123456789ABCDEF;
  localparam logic [1:64] CT_FIPS = 64'h85E813540F0AB405;
  localparam logic [1:64] CT_ZERO = 64'h8CA64DE9C1B123A7;
  localparam int          LAT     = 33;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic         d_start, d_ready, d_busy, d_done;
  logic [1:64]  d_ct, d_res;
  logic [1:768] d_keys;
  logic         e_start, e_ready, e_busy, e_done;
  logic [1:64]  e_ct, e_res;
  logic [1:768] e_keys;

  des_decryption_iterative #(.REVERSE_KEYS(1), .ROUNDS(16)) dut (
    .clk(clk), .rst(rst), .start(d_start), .ready(d_ready), .ciphertext(d_ct),
    .round_keys(d_keys), .busy(d_busy), .done(d_done), .result(d_res));

  des_decryption_iterative #(.REVERSE_KEYS(0), .ROUNDS(16)) dut_enc (
    .clk(clk), .rst(rst), .start(e_start), .ready(e_ready), .ciphertext(e_ct),
    .round_keys(e_keys), .busy(e_busy), .done(e_done), .result(e_res));

  int checks = 0;
  int errors = 0;
  int d_done_cnt = 0;
  int e_done_cnt = 0;
  logic [1:64] d_q [$];
  logic [1:64] e_q [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [1:768] key_sched(input logic [1:64] key);
    logic [1:56]  cd;
    logic [1:28]  c;
    logic [1:28]  d;
    logic [1:768] rk;
    rk = '0;
    for (int i = 0; i < 56; i++) cd[i+1] = key[PC1_T[i]];
    c = cd[1:28];
    d = cd[29:56];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        c = {c[2:28], c[1]};
        d = {d[2:28], d[1]};
      end
      cd = {c, d};
      for (int j = 0; j < 48; j++) rk[r*48 + j + 1] = cd[PC2_T[j]];
    end
    return rk;
  endfunction

  // Scoreboards: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && d_done) begin
      d_done_cnt++;
      checks++;
      assert (d_q.size() > 0) else begin
        errors++;
        $error("FAIL d_unexpected_done: observed result %h with no operation outstanding", d_res);
      end
      if (d_q.size() > 0) chk("d_result", d_res, d_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (!rst && e_done) begin
      e_done_cnt++;
      checks++;
      assert (e_q.size() > 0) else begin
        errors++;
        $error("FAIL e_unexpected_done: observed result %h with no operation outstanding", e_res);
      end
      if (e_q.size() > 0) chk("e_result", e_res, e_q.pop_front());
    end
  end

  task automatic d_go(input logic [1:64] ct, input logic [1:768] k, input logic [1:64] exp);
    d_ct    = ct;
    d_keys  = k;
    d_start = 1'b1;
    d_q.push_back(exp);
    @(negedge clk);
    d_start = 1'b0;
  endtask

  task automatic e_go(input logic [1:64] ct, input logic [1:768] k, input logic [1:64] exp);
    e_ct    = ct;
    e_keys  = k;
    e_start = 1'b1;
    e_q.push_back(exp);
    @(negedge clk);
    e_start = 1'b0;
  endtask

  // lat counts negedges since the one just before the accepting posedge.
  task automatic d_wait(input int from, output int lat);
    lat = from;
    while (!d_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    assert (d_done) else begin
      errors++;
      $error("FAIL d_timeout: observed no done after %0d cycles, required done", lat);
    end
  endtask

  task automatic e_wait(output int lat);
    lat = 1;
    while (!e_done && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    checks++;
    assert (e_done) else begin
      errors++;
      $error("FAIL e_timeout: observed no done after %0d cycles, required done", lat);
    end
  endtask

  initial begin
    logic [1:768] kf;
    int lat;
    int exp_d_done;
    kf         = key_sched(64'h133457799BBCDFF1);
    exp_d_done = 0;
    rst = 1'b1;
    d_start = 1'b0; d_ct = '0; d_keys = '0;
    e_start = 1'b0; e_ct = '0; e_keys = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    chk("reset_ready", 64'(d_ready), 64'd1);
    chk("reset_busy",  64'(d_busy),  64'd0);
    chk("reset_done",  64'(d_done),  64'd0);
    chk("reset_result", d_res, 64'd0);
    chk("reset_e_result", e_res, 64'd0);

    // FIPS decrypt with full latency and single-pulse checks
    d_go(CT_FIPS, kf, PT_FIPS);
    chk("fips_busy",  64'(d_busy),  64'd1);
    chk("fips_ready", 64'(d_ready), 64'd0);
    d_wait(1, lat);
    exp_d_done++;
    chk("fips_latency", 64'(lat), 64'(LAT));
    chk("fips_busy_at_done",  64'(d_busy),  64'd0);
    chk("fips_ready_at_done", 64'(d_ready), 64'd1);
    @(negedge clk);
    chk("fips_done_single", 64'(d_done), 64'd0);
    chk("fips_result_held", d_res, PT_FIPS);

    // Encrypt-order instance, then decrypt its output
    e_go(PT_FIPS, kf, CT_FIPS);
    e_wait(lat);
    chk("enc_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    d_go(e_res, kf, PT_FIPS);
    d_wait(1, lat);
    exp_d_done++;
    chk("roundtrip_latency", 64'(lat), 64'(LAT));
    @(negedge clk);

    // Back-to-back: second start issued in the done cycle of the first
    d_go(CT_FIPS, kf, PT_FIPS);
    d_wait(1, lat);
    exp_d_done++;
    chk("b2b_ready_in_done", 64'(d_ready), 64'd1);
    d_go(CT_ZERO, '0, 64'h0);
    chk("b2b_no_gap_busy", 64'(d_busy), 64'd1);
    repeat (10) @(negedge clk);
    chk("b2b_first_result_stable", d_res, PT_FIPS);
    d_wait(11, lat);
    exp_d_done++;
    chk("b2b_second_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    chk("b2b_second_result", d_res, 64'h0);

    // Start while busy plus input corruption after accept
    d_go(CT_FIPS, kf, PT_FIPS);
    repeat (4) @(negedge clk);
    d_start = 1'b1;
    d_ct    = '1;
    d_keys  = '1;
    @(negedge clk);
    d_start = 1'b0;
    d_wait(6, lat);
    exp_d_done++;
    chk("corrupt_latency", 64'(lat), 64'(LAT));
    repeat (45) @(negedge clk);
    chk("corrupt_no_queued_start", 64'(d_done_cnt), 64'(exp_d_done));

    // Reset during round 8
    d_go(CT_FIPS, kf, PT_FIPS);
    repeat (14) @(negedge clk);
    chk("midreset_busy_before", 64'(d_busy), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    d_q.delete();
    chk("midreset_ready",  64'(d_ready), 64'd1);
    chk("midreset_busy",   64'(d_busy),  64'd0);
    chk("midreset_done",   64'(d_done),  64'd0);
    chk("midreset_result", d_res, 64'h0);
    repeat (40) @(negedge clk);
    chk("midreset_no_done", 64'(d_done_cnt), 64'(exp_d_done));

    d_go(CT_FIPS, kf, PT_FIPS);
    d_wait(1, lat);
    exp_d_done++;
    chk("after_reset_latency", 64'(lat), 64'(LAT));
    @(negedge clk);
    chk("after_reset_result", d_res, PT_FIPS);
    chk("total_d_done", 64'(d_done_cnt), 64'(exp_d_done));
    chk("total_e_done", 64'(e_done_cnt), 64'd1);
    chk("d_queue_drained", 64'(d_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/des_decryption_iterative.md
Name: des_decryption_iterative

Overview:
- Iterative DES decryption engine, the inverse direction of the team's fully unrolled DES encryption datapath.
- Reuses a single des_roundfunction instance for 16 rounds, applying round keys in reverse order (K16 first, K1 last).
- Brackets the rounds with the team's ip_permutation and ip_inverse_permutation primitives.
- Intended for area-constrained configurations where one decrypt per ~35 cycles is acceptable.

Parameters:
- REVERSE_KEYS, 1: 1 = decrypt (round i uses key 17-i); 0 = encrypt key order (debug/self-check).
- ROUNDS, 16: rounds executed. Must be 16 for DES-compliant output; smaller values are for debug only.

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  synchronous reset, active-high; drives the round function's rst_n as ~rst
- start  in  1  request; sampled only when ready=1
- ready  out  1  1 in IDLE (start accepted this cycle)
- ciphertext  in  [1:64]  block to decrypt; latched on accept
- round_keys  in  [1:768]  K1 at [1:48] ... K16 at [721:768]; latched on accept
- busy  out  1  1 from the cycle after accept until done
- done  out  1  one-cycle registered pulse; result valid
- result  out  [1:64]  plaintext; held until the next accept

Behaviour:
- Reset (synchronous): state=IDLE, round counter=0, L/R/key registers=0, result=0, done=0, busy=0, ready=1 after the reset cycle. Reset mid-operation aborts immediately; no done pulse is produced.
- States:
  - IDLE: ready=1. On start=1: latch {L,R} = IP(ciphertext) and round_keys, set cnt=0, go to RSTART.
  - RSTART: drive round-function start=1 for exactly one cycle, with L_in/R_in from the L/R registers and Kn = key(cnt). Go to RWAIT.
  - RWAIT: hold inputs stable. When round-function done=1, capture L<=L_out, R<=R_out. If cnt==ROUNDS-1, go to IDLE, load result <= IP^-1({R_out, L_out}) and set done=1 for the next cycle. Otherwise cnt<=cnt+1 and go to RSTART.
- Key select: with REVERSE_KEYS=1, key(cnt) = round_keys bits [(15-cnt)*48+1 : (15-cnt)*48+48]. With REVERSE_KEYS=0, key(cnt) = bits [cnt*48+1 : cnt*48+48].
- cnt is 4 bits. It never wraps, because the terminal compare happens before increment.
- Round-function contract: any latency Lr>=1 cycles from start to done. L_out/R_out are sampled only in the cycle where done=1. A done seen in IDLE or RSTART is ignored.
- Latency: accept at edge T gives done=1 during cycle T + ROUNDS*(Lr+1) + 1. For Lr=1 that is 33 cycles.
- busy=1 in RSTART/RWAIT. It deasserts in the same cycle that done asserts, and ready returns to 1 in that cycle.
- start while busy is ignored; no queuing. start in the same cycle as done (state IDLE) is accepted, giving back-to-back operation.
- Changes to ciphertext/round_keys after accept do not affect the operation in flight.
- result changes only on completion of an operation.

Test Plan:
- Reset then idle: rst=1 for 2 cycles -> ready=1, busy=0, done=0, result=0.
- FIPS vector: key 133457799BBCDFF1 (bench-generated K1..K16), ciphertext 85E813540F0AB405 -> result=0123456789ABCDEF, done pulses exactly once, at accept+33 with Lr=1.
- Round trip with REVERSE_KEYS=0: plaintext 0123456789ABCDEF with the same keys -> 85E813540F0AB405. Then feed that result back through a REVERSE_KEYS=1 instance -> 0123456789ABCDEF.
- Back-to-back: assert start in the done cycle with a second vector (all-zero key schedule, ciphertext 8CA64DE9C1B123A7) -> second result=0000000000000000, no idle gap, first result stable until then.
- Start during busy, plus input corruption: pulse start and change ciphertext/round_keys to FFFF... mid-operation -> ignored, the original result is still produced.
- Reset mid-operation: assert rst in round 8 -> no done pulse, ready=1 next cycle, result=0. A new start then completes correctly.
